sirali_hesap_cekirdegi: RTL

//  Parametrised, multi-cycle successor of the calculator datapath. Unsigned add, sub,
//  mul, div and integer sqrt on WIDTH-bit operands, selected by tur.
//  Mul, div and sqrt are iterative (one bit per clock), replacing wide combinational units.

---
 rtl/sirali_hesap_cekirdegi.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sirali_hesap_cekirdegi.sv
// Multi-cycle unsigned calculator core: add/sub in one step, mul/div one bit per clock,
// integer sqrt one bit-pair per clock, behind a basla/hazir/gecerli handshake.
module sirali_hesap_cekirdegi #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 basla,
  input  logic [2:0]           tur,
  input  logic [WIDTH-1:0]     sayi1,
  input  logic [WIDTH-1:0]     sayi2,
  output logic                 hazir,
  output logic [2*WIDTH-1:0]   sonuc,
  output logic                 tasma,
  output logic                 hata,
  output logic                 gecerli
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SQRT = 3'b100;

  typedef enum logic {BOS, HESAP} durum_t;

  durum_t            state_q, state_d;
  logic [2:0]        tur_q, tur_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     sonuc_q, sonuc_d;
  logic              tasma_q, tasma_d;
  logic              hata_q, hata_d;
  logic              gecerli_q, gecerli_d;

  logic [WIDTH:0]    add_sum, sub_dif;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_acc;
  logic [WIDTH:0]    div_sh, div_dif;
  logic              div_ge;
  logic [WIDTH-1:0]  div_rem, div_quo;
  logic [H+2:0]      sq_sh, sq_trial, sq_dif;
  logic              sq_ge;
  logic [WIDTH-1:0]  sq_rem;
  logic [H-1:0]      sq_root;

  // One iteration step of each iterative unit, evaluated from the working registers.
  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_dif  = {1'b0, a_q} - {1'b0, b_q};

    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};

    div_sh   = {rem_q, a_q[WIDTH-1]};
    div_dif  = div_sh - {1'b0, b_q};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_rem  = WIDTH'(div_ge ? div_dif : div_sh);
    div_quo  = {a_q[WIDTH-2:0], div_ge};

    sq_sh    = {rem_q[H:0], a_q[WIDTH-1:WIDTH-2]};
    sq_trial = {1'b0, acc_q[H-1:0], 2'b01};
    sq_dif   = sq_sh - sq_trial;
    sq_ge    = (sq_sh >= sq_trial);
    sq_rem   = WIDTH'(sq_ge ? sq_dif : sq_sh);
    sq_root  = {acc_q[H-2:0], sq_ge};
  end

  // Next-state: accept in BOS, iterate in HESAP, publish results on the last count.
  always_comb begin
    state_d   = state_q;
    tur_d     = tur_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sonuc_d   = sonuc_q;
    tasma_d   = tasma_q;
    hata_d    = hata_q;
    gecerli_d = 1'b0;

    case (state_q)
      BOS: begin
        if (basla) begin
          state_d = HESAP;
          tur_d   = tur;
          a_d     = sayi1;
          b_d     = sayi2;
          acc_d   = '0;
          rem_d   = '0;
          case (tur)
            OP_MUL:  cnt_d = CW'(WIDTH);
            OP_DIV:  cnt_d = (sayi2 == '0) ? CW'(1) : CW'(WIDTH);
            OP_SQRT: cnt_d = CW'(H);
            default: cnt_d = CW'(1);
          endcase
        end
      end

      HESAP: begin
        case (tur_q)
          OP_MUL: begin
            acc_d = mul_acc;
            b_d   = b_q >> 1;
          end
          OP_DIV: begin
            rem_d = div_rem;
            a_d   = div_quo;
          end
          OP_SQRT: begin
            rem_d = sq_rem;
            acc_d = W2'(sq_root);
            a_d   = a_q << 2;
          end
          default: ;
        endcase
        cnt_d = cnt_q - CW'(1);

        if (cnt_q == CW'(1)) begin
          state_d   = BOS;
          gecerli_d = 1'b1;
          sonuc_d   = '0;
          tasma_d   = 1'b0;
          hata_d    = 1'b0;
          case (tur_q)
            OP_ADD: begin
              sonuc_d = W2'(add_sum);
              tasma_d = add_sum[WIDTH];
            end
            OP_SUB: begin
              sonuc_d = W2'(sub_dif[WIDTH-1:0]);
              tasma_d = sub_dif[WIDTH];
            end
            OP_MUL:  sonuc_d = mul_acc;
            OP_DIV: begin
              // Divide by zero takes the single-count path and reports only hata.
              if (b_q == '0) hata_d = 1'b1;
              else           sonuc_d = {div_rem, div_quo};
            end
            OP_SQRT: sonuc_d = W2'(sq_root);
            default: hata_d = 1'b1;
          endcase
        end
      end

      default: state_d = BOS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOS;
      tur_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sonuc_q   <= '0;
      tasma_q   <= 1'b0;
      hata_q    <= 1'b0;
      gecerli_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tur_q     <= tur_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sonuc_q   <= sonuc_d;
      tasma_q   <= tasma_d;
      hata_q    <= hata_d;
      gecerli_q <= gecerli_d;
    end
  end

  assign hazir   = (state_q == BOS);
  assign sonuc   = sonuc_q;
  assign tasma   = tasma_q;
  assign hata    = hata_q;
  assign gecerli = gecerli_q;

endmodule
